cpu_mem_responder: RTL and testbench



---
 rtl/cpu8_mem_pkg.sv | 21 ++
 rtl/mem_array_256x8.sv | 32 +++
 rtl/cpu_mem_responder.sv | 107 ++++++++++
 tb/tb_cpu_mem_responder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu8_mem_pkg.sv
// Shared constants, FSM states and access encodings for the CPU memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu8_mem_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 256;

  // Responder operating mode: waiting, streaming a program in, or serving the CPU.
  typedef enum logic [1:0] {
    HOLD = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Meaning of read_enable while Csel is high.
  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

endpackage

// File: rtl/mem_array_256x8.sv
// Single-port synchronous RAM with a registered read port.
// Latency: write lands on the clock edge; read data appears one edge after re.
// Backpressure: none; accepts one access per cycle, rdata holds when re is low.
module mem_array_256x8 #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  // Storage is deliberately not reset so a program survives a responder reset.
  logic [DATA_W-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Read register: only updates on a read, otherwise keeps the last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory responder for the 8-bit CPU bus plus a program loader that fills RAM before release.
// Latency: CPU reads return one edge after the request; loader bytes are written on acceptance.
// Backpressure: load_ready is high only in LOAD; CPU accesses are ignored outside RUN.
module cpu_mem_responder #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Csel,
  input  logic              read_enable,
  input  logic [ADDR_W-1:0] ipnext,
  input  logic [DATA_W-1:0] ram_write_data,
  output logic [DATA_W-1:0] ram_dataout,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic [ADDR_W:0]   load_count,
  output logic              cpu_run
);

  import cpu8_mem_pkg::*;

  state_t            state, state_next;
  logic [ADDR_W:0]   count_next;
  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HOLD;
    else     state <= state_next;
  end

  // Next state, loader handshake and RAM port steering between loader and CPU.
  always_comb begin
    state_next = state;
    count_next = load_count;
    load_ready = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_addr   = ipnext;
    mem_wdata  = ram_write_data;
    case (state)
      HOLD: begin
        if (load_start) begin
          state_next = LOAD;
          count_next = '0;
        end
      end
      LOAD: begin
        load_ready = 1'b1;
        mem_addr   = load_count[ADDR_W-1:0];
        mem_wdata  = load_data;
        // A restart drops whatever byte is offered in the same cycle.
        if (load_start) begin
          count_next = '0;
        end else if (load_valid) begin
          mem_we     = 1'b1;
          count_next = load_count + 1'b1;
          // Filling the last word ends the load so the address never wraps.
          if (load_last || load_count == (ADDR_W+1)'(DEPTH-1)) state_next = RUN;
        end
      end
      RUN: begin
        mem_we = Csel && (read_enable == WRITE);
        mem_re = Csel && (read_enable == READ);
        // The CPU access in this cycle is still serviced before reloading.
        if (load_start) begin
          state_next = LOAD;
          count_next = '0;
        end
      end
      default: state_next = HOLD;
    endcase
  end

  // Byte counter and CPU release flag, both tracking the chosen next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_count <= '0;
      cpu_run    <= 1'b0;
    end else begin
      load_count <= count_next;
      cpu_run    <= (state_next == RUN);
    end
  end

  mem_array_256x8 #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (ram_dataout)
  );

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed and randomized bench for the CPU memory responder against a byte-array model.
// Latency: inputs driven on the falling edge, outputs sampled on the next falling edge.
// Backpressure: loader bytes are only offered while the bench expects LOAD.
module tb_cpu_mem_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       Csel = 1'b0;
  logic       read_enable = 1'b0;
  logic [7:0] ipnext = '0;
  logic [7:0] ram_write_data = '0;
  logic [7:0] ram_dataout;
  logic       load_start = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = '0;
  logic       load_last = 1'b0;
  logic       load_ready;
  logic [8:0] load_count;
  logic       cpu_run;

  int checks = 0;
  int errors = 0;

  // Reference model: the RAM as a plain byte array plus the last read value.
  logic [7:0] model_mem [256];
  logic [7:0] exp_dout;

  always #5 clk = ~clk;

  cpu_mem_responder dut (
    .clk            (clk),
    .rst            (rst),
    .Csel           (Csel),
    .read_enable    (read_enable),
    .ipnext         (ipnext),
    .ram_write_data (ram_write_data),
    .ram_dataout    (ram_dataout),
    .load_start     (load_start),
    .load_valid     (load_valid),
    .load_data      (load_data),
    .load_last      (load_last),
    .load_ready     (load_ready),
    .load_count     (load_count),
    .cpu_run        (cpu_run)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_bus();
    Csel = 1'b0; read_enable = 1'b0; load_start = 1'b0;
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] a);
    Csel = 1'b1; read_enable = 1'b1; ipnext = a;
    step();
    exp_dout = model_mem[a];
    Csel = 1'b0;
  endtask

  initial begin
    logic [7:0] a, d;
    logic       cs, rd;

    // Reset then idle.
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    repeat (5) step();
    check("reset_cpu_run", 32'(cpu_run), 0);
    check("reset_load_ready", 32'(load_ready), 0);
    check("reset_dout", 32'(ram_dataout), 0);
    check("reset_count", 32'(load_count), 0);

    // CPU access in HOLD is ignored.
    Csel = 1'b1; read_enable = 1'b0; ipnext = 8'h00; ram_write_data = 8'hEE;
    step();
    Csel = 1'b0;
    check("hold_no_ready", 32'(load_ready), 0);

    // Short load with a gap (stray load_last without valid) and an explicit last byte.
    load_start = 1'b1; step(); load_start = 1'b0;
    check("short_ready", 32'(load_ready), 1);
    load_valid = 1'b1; load_data = 8'hA1; step();
    load_valid = 1'b0; load_last = 1'b1; step();
    check("gap_still_loading", 32'(load_ready), 1);
    check("gap_count", 32'(load_count), 1);
    load_valid = 1'b1; load_last = 1'b0; load_data = 8'hB2; step();
    load_last = 1'b1; load_data = 8'hC3; step();
    idle_bus();
    model_mem[0] = 8'hA1; model_mem[1] = 8'hB2; model_mem[2] = 8'hC3;
    check("short_count", 32'(load_count), 3);
    check("short_ready_off", 32'(load_ready), 0);
    step();
    check("short_cpu_run", 32'(cpu_run), 1);
    for (int i = 0; i < 3; i++) begin
      cpu_read(8'(i));
      check("short_read", 32'(ram_dataout), 32'(exp_dout));
    end

    // Full load with no load_last: must stop after the last address.
    load_start = 1'b1; step(); load_start = 1'b0;
    check("full_count_clear", 32'(load_count), 0);
    check("full_cpu_held", 32'(cpu_run), 0);
    for (int i = 0; i < 256; i++) begin
      load_valid = 1'b1; load_data = 8'(i) ^ 8'h5A;
      model_mem[i] = 8'(i) ^ 8'h5A;
      step();
    end
    idle_bus();
    check("full_count", 32'(load_count), 256);
    check("full_ready_off", 32'(load_ready), 0);
    step();
    check("full_ready_stays_off", 32'(load_ready), 0);
    check("full_cpu_run", 32'(cpu_run), 1);
    check("full_count_holds", 32'(load_count), 256);
    cpu_read(8'hFF);
    check("full_read_ff", 32'(ram_dataout), 32'h0A5);
    cpu_read(8'h00);
    check("full_read_00", 32'(ram_dataout), 32'h05A);

    // CPU write then read-after-write; dout holds across write and idle cycles.
    Csel = 1'b1; read_enable = 1'b0; ipnext = 8'h80; ram_write_data = 8'h3C;
    model_mem[8'h80] = 8'h3C;
    step();
    check("write_holds_dout", 32'(ram_dataout), 32'h05A);
    cpu_read(8'h80);
    check("raw_read", 32'(ram_dataout), 32'h03C);
    step(); step();
    check("idle_holds_dout", 32'(ram_dataout), 32'h03C);

    // Randomized CPU traffic in RUN.
    for (int n = 0; n < 200; n++) begin
      cs = 1'($urandom); rd = 1'($urandom);
      a = 8'($urandom); d = 8'($urandom);
      Csel = cs; read_enable = rd; ipnext = a; ram_write_data = d;
      step();
      if (cs && rd) exp_dout = model_mem[a];
      if (cs && !rd) model_mem[a] = d;
      check("rand_dout", 32'(ram_dataout), 32'(exp_dout));
    end
    idle_bus();
    check("rand_cpu_run", 32'(cpu_run), 1);

    // Reload during RUN while the CPU reads address 1.
    Csel = 1'b1; read_enable = 1'b1; ipnext = 8'h01; load_start = 1'b1;
    step();
    idle_bus();
    check("reload_read_serviced", 32'(ram_dataout), 32'(model_mem[1]));
    check("reload_cpu_run_off", 32'(cpu_run), 0);
    check("reload_count_clear", 32'(load_count), 0);
    check("reload_ready", 32'(load_ready), 1);
    load_valid = 1'b1; load_last = 1'b1; load_data = 8'h11; step();
    idle_bus();
    model_mem[0] = 8'h11;
    check("reload_count", 32'(load_count), 1);
    step();
    cpu_read(8'h00);
    check("reload_mem0", 32'(ram_dataout), 32'(exp_dout));
    cpu_read(8'h01);
    check("reload_mem1_kept", 32'(ram_dataout), 32'(exp_dout));

    // Restart inside LOAD drops the byte offered with load_start.
    load_start = 1'b1; step(); load_start = 1'b0;
    load_valid = 1'b1; load_data = 8'h44; step();
    load_start = 1'b1; load_data = 8'h55; step();
    load_start = 1'b0;
    check("restart_count_clear", 32'(load_count), 0);
    check("restart_still_loading", 32'(load_ready), 1);
    load_data = 8'h66; load_last = 1'b1; step();
    idle_bus();
    model_mem[0] = 8'h66;
    check("restart_count", 32'(load_count), 1);
    step();
    cpu_read(8'h00);
    check("restart_mem0", 32'(ram_dataout), 32'(exp_dout));

    // Asynchronous reset mid-load.
    load_start = 1'b1; step(); load_start = 1'b0;
    load_valid = 1'b1; load_data = 8'h21; step();
    load_data = 8'h22; step();
    load_valid = 1'b0;
    model_mem[0] = 8'h21; model_mem[1] = 8'h22;
    check("preload_count", 32'(load_count), 2);
    rst = 1'b1;
    #1;
    check("rst_cpu_run", 32'(cpu_run), 0);
    check("rst_load_ready", 32'(load_ready), 0);
    check("rst_count", 32'(load_count), 0);
    check("rst_dout", 32'(ram_dataout), 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("rst_hold_state", 32'(load_ready), 0);
    load_start = 1'b1; step(); load_start = 1'b0;
    load_valid = 1'b1; load_last = 1'b1; load_data = 8'h33; step();
    idle_bus();
    model_mem[0] = 8'h33;
    step();
    check("post_rst_run", 32'(cpu_run), 1);
    cpu_read(8'h01);
    check("post_rst_mem1", 32'(ram_dataout), 32'(exp_dout));
    cpu_read(8'h00);
    check("post_rst_mem0", 32'(ram_dataout), 32'(exp_dout));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
